// File: rtl/dual_port_ram_be_if.sv
// -----------------------------------------------------------------------------
// dual_port_ram_be_if
// Bus bundle for dual_port_ram_be: one write port, one read port, plus status.
//
// Parameters:
//   DATA_WIDTH - word width in bits (multiple of 8); must match the RAM.
//   ADDR_WIDTH - address width; must match the RAM.
//
// Signals:
//   data_in, byte_en, write_addr, we : write port (master -> slave)
//   read_addr, re                    : read request (master -> slave)
//   data_out, data_valid             : read response (slave -> master)
//   busy                             : high while the post-reset clear runs
//   parity_error                     : only with DUAL_PORT_RAM_BE_PARITY_EN defined
//
// Modports: master (the RAM user), slave (the RAM).
// -----------------------------------------------------------------------------
interface dual_port_ram_be_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 12
) ();
    logic [DATA_WIDTH-1:0]   data_in;
    logic [DATA_WIDTH/8-1:0] byte_en;
    logic [ADDR_WIDTH-1:0]   write_addr;
    logic                    we;
    logic [ADDR_WIDTH-1:0]   read_addr;
    logic                    re;
    logic [DATA_WIDTH-1:0]   data_out;
    logic                    data_valid;
    logic                    busy;
`ifdef DUAL_PORT_RAM_BE_PARITY_EN
    logic                    parity_error;
`endif

    modport master (
        output data_in, byte_en, write_addr, we, read_addr, re,
`ifdef DUAL_PORT_RAM_BE_PARITY_EN
        input  parity_error,
`endif
        input  data_out, data_valid, busy
    );

    modport slave (
        input  data_in, byte_en, write_addr, we, read_addr, re,
`ifdef DUAL_PORT_RAM_BE_PARITY_EN
        output parity_error,
`endif
        output data_out, data_valid, busy
    );
endinterface

// File: rtl/dual_port_ram_be.sv
// -----------------------------------------------------------------------------
// dual_port_ram_be
// Single-clock simple dual-port RAM with per-byte write enables, a qualified
// read (re -> data_valid), 1- or 2-cycle read latency, write-first forwarding
// for same-address write/read on the same edge, and a post-reset clear
// sequencer that zeroes every word before the RAM reports ready.
//
// Optional feature: define DUAL_PORT_RAM_BE_PARITY_EN to store one even-parity
// bit per byte lane and report bus.parity_error alongside data_valid.
//
// Parameters:
//   DATA_WIDTH     - word width (multiple of 8)
//   ADDR_WIDTH     - depth is 2**ADDR_WIDTH words
//   OUTPUT_REG     - 0: read latency 1, 1: extra output register, latency 2
//   CLEAR_ON_RESET - 1: zero all words after reset, 0: start ready immediately
//
// Ports:
//   clock - sole clock, rising edge
//   reset - asynchronous, active-high
//   bus   - dual_port_ram_be_if.slave (write port, read port, data_out,
//           data_valid, busy[, parity_error])
// -----------------------------------------------------------------------------
module dual_port_ram_be #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 12,
    parameter int OUTPUT_REG     = 0,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                clock,
    input  logic                reset,
    dual_port_ram_be_if.slave   bus
);
    localparam int LANES = DATA_WIDTH / 8;
    localparam int DEPTH = 1 << ADDR_WIDTH;
`ifdef DUAL_PORT_RAM_BE_PARITY_EN
    // Parity bits live above the data bits: [DATA_WIDTH + lane].
    localparam int MEM_W = DATA_WIDTH + LANES;
`else
    localparam int MEM_W = DATA_WIDTH;
`endif

    typedef enum logic {
        ST_CLEAR,
        ST_READY
    } state_t;

    state_t                state_reg;
    logic [ADDR_WIDTH-1:0] clear_cnt_reg;
    logic                  busy_reg;

    // ---------------------------------------------------------------------
    // Clear sequencer: one word per cycle, READY after the last address.
    // ---------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg     <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
            busy_reg      <= (CLEAR_ON_RESET != 0);
            clear_cnt_reg <= '0;
        end else begin
            case (state_reg)
                ST_CLEAR: begin
                    clear_cnt_reg <= clear_cnt_reg + 1'b1;
                    if (clear_cnt_reg == {ADDR_WIDTH{1'b1}}) begin
                        state_reg <= ST_READY;
                        busy_reg  <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= ST_READY;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy = busy_reg;

    // ---------------------------------------------------------------------
    // Write word formation (data plus optional freshly generated parity)
    // ---------------------------------------------------------------------
    logic [MEM_W-1:0] wr_word;
    logic [MEM_W-1:0] merged_word;
    logic [MEM_W-1:0] rd_raw_reg;
    logic [MEM_W-1:0] fwd_word_reg;
    logic [LANES-1:0] fwd_be_reg;
`ifdef DUAL_PORT_RAM_BE_PARITY_EN
    logic [LANES-1:0] lane_err;
`endif

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            assign wr_word[gi*8 +: 8] = bus.data_in[gi*8 +: 8];
            // Forwarded lanes take the write data captured on the issue edge,
            // the rest come from the array's pre-write contents.
            assign merged_word[gi*8 +: 8] = fwd_be_reg[gi] ? fwd_word_reg[gi*8 +: 8]
                                                           : rd_raw_reg[gi*8 +: 8];
`ifdef DUAL_PORT_RAM_BE_PARITY_EN
            assign wr_word[DATA_WIDTH+gi]     = ^bus.data_in[gi*8 +: 8];
            assign merged_word[DATA_WIDTH+gi] = fwd_be_reg[gi] ? fwd_word_reg[DATA_WIDTH+gi]
                                                               : rd_raw_reg[DATA_WIDTH+gi];
            assign lane_err[gi] = (^merged_word[gi*8 +: 8]) ^ merged_word[DATA_WIDTH+gi];
`endif
        end
    endgenerate

    // Memory write port: the clear sequencer owns it while busy.
    logic                  mem_we;
    logic [LANES-1:0]      mem_be;
    logic [ADDR_WIDTH-1:0] mem_waddr;
    logic [MEM_W-1:0]      mem_wdata;
    logic                  rd_accept;

    always_comb begin
        mem_we    = 1'b0;
        mem_be    = '0;
        mem_waddr = '0;
        mem_wdata = '0;
        if (state_reg == ST_CLEAR) begin
            mem_we    = 1'b1;
            mem_be    = '1;
            mem_waddr = clear_cnt_reg;
        end else begin
            mem_we    = bus.we;
            mem_be    = bus.byte_en;
            mem_waddr = bus.write_addr;
            mem_wdata = wr_word;
        end
    end

    assign rd_accept = bus.re && (state_reg == ST_READY);

    // ---------------------------------------------------------------------
    // Storage: no reset so it maps onto block RAM; read is registered and
    // returns the contents as of the issue edge (read-before-write in the
    // array; write-first behaviour is rebuilt by the forwarding merge).
    // ---------------------------------------------------------------------
    logic [MEM_W-1:0] mem_array [DEPTH];

    always_ff @(posedge clock) begin
        if (mem_we) begin
            for (int i = 0; i < LANES; i++) begin
                if (mem_be[i]) begin
                    mem_array[mem_waddr][i*8 +: 8] <= mem_wdata[i*8 +: 8];
`ifdef DUAL_PORT_RAM_BE_PARITY_EN
                    mem_array[mem_waddr][DATA_WIDTH+i] <= mem_wdata[DATA_WIDTH+i];
`endif
                end
            end
        end
        if (rd_accept) begin
            rd_raw_reg <= mem_array[bus.read_addr];
        end
    end

    // Stage 1: read qualifier and same-address forwarding capture.
    logic valid1_reg;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid1_reg   <= 1'b0;
            fwd_be_reg   <= '0;
            fwd_word_reg <= '0;
        end else begin
            valid1_reg <= rd_accept;
            if (rd_accept) begin
                fwd_be_reg   <= (bus.we && (bus.write_addr == bus.read_addr)) ? bus.byte_en : '0;
                fwd_word_reg <= wr_word;
            end
        end
    end

    logic perr_s1;
`ifdef DUAL_PORT_RAM_BE_PARITY_EN
    assign perr_s1 = |lane_err;
`else
    assign perr_s1 = 1'b0;
`endif

    // Holding register: keeps data_out stable between valid reads.
    logic [DATA_WIDTH-1:0] hold_data_reg;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hold_data_reg <= '0;
        end else if (valid1_reg) begin
            hold_data_reg <= merged_word[DATA_WIDTH-1:0];
        end
    end

    // ---------------------------------------------------------------------
    // Output stage selection
    // ---------------------------------------------------------------------
    generate
        if (OUTPUT_REG != 0) begin : g_out_reg
            logic valid2_reg;
            logic perr2_reg;

            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    valid2_reg <= 1'b0;
                    perr2_reg  <= 1'b0;
                end else begin
                    valid2_reg <= valid1_reg;
                    perr2_reg  <= valid1_reg & perr_s1;
                end
            end

            assign bus.data_out   = hold_data_reg;
            assign bus.data_valid = valid2_reg;
`ifdef DUAL_PORT_RAM_BE_PARITY_EN
            assign bus.parity_error = valid2_reg & perr2_reg;
`endif
        end else begin : g_out_direct
            // Only registers feed this mux, so data_out has no input-to-output path.
            assign bus.data_out   = valid1_reg ? merged_word[DATA_WIDTH-1:0] : hold_data_reg;
            assign bus.data_valid = valid1_reg;
`ifdef DUAL_PORT_RAM_BE_PARITY_EN
            assign bus.parity_error = valid1_reg & perr_s1;
`endif
        end
    endgenerate

`ifndef DUAL_PORT_RAM_BE_PARITY_EN
    // perr_s1 is a constant when parity storage is absent.
    logic unused_perr;
    assign unused_perr = perr_s1;
`endif

endmodule

// File: tb/tb_dual_port_ram_be.sv
// -----------------------------------------------------------------------------
// tb_dual_port_ram_be
// Directed bench for dual_port_ram_be (ADDR_WIDTH = 4, DATA_WIDTH = 32).
// Stimulus pushes expected read results into a scoreboard queue; a monitor
// pops and compares whenever data_valid is seen, including the cycle on which
// it arrives.
// -----------------------------------------------------------------------------
module tb_dual_port_ram_be;
    localparam int DW = 32;
    localparam int AW = 4;
    parameter int OUTPUT_REG = 0;

    logic clk;
    logic reset;
    int   cycle_cnt;
    int   n_cmp;
    int   n_mis;

    typedef struct {
        logic [DW-1:0] data;
        logic          perr;
        int            cyc;
    } exp_t;

    exp_t sb_q[$];

    dual_port_ram_be_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    dual_port_ram_be #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .OUTPUT_REG(OUTPUT_REG),
        .CLEAR_ON_RESET(1)
    ) dut (
        .clock(clk),
        .reset(reset),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cycle_cnt = 0;
    always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        logic perr_act;
        exp_t e;
`ifdef DUAL_PORT_RAM_BE_PARITY_EN
        perr_act = bus.parity_error;
`else
        perr_act = 1'b0;
`endif
        if (bus.data_valid === 1'b1) begin
            n_cmp++;
            if (sb_q.size() == 0) begin
                n_mis++;
                $display("FAIL unexpected_valid: data_out=%h at cycle %0d, no read outstanding",
                         bus.data_out, cycle_cnt);
            end else begin
                e = sb_q.pop_front();
                if (bus.data_out !== e.data || perr_act !== e.perr || cycle_cnt != e.cyc) begin
                    n_mis++;
                    $display("FAIL read_data: got data=%h perr=%b cycle=%0d, want data=%h perr=%b cycle=%0d",
                             bus.data_out, perr_act, cycle_cnt, e.data, e.perr, e.cyc);
                end else begin
                    $display("read ok: data=%h perr=%b cycle=%0d", bus.data_out, perr_act, cycle_cnt);
                end
            end
        end else if (sb_q.size() != 0 && sb_q[0].cyc <= cycle_cnt) begin
            e = sb_q.pop_front();
            n_cmp++;
            n_mis++;
            $display("FAIL missing_valid: data_valid=0 at cycle %0d, want data=%h", cycle_cnt, e.data);
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end else begin
            $display("check ok: %s = %h", name, act);
        end
    endtask

    // One bus cycle, driven just after a falling edge.
    task automatic op(input logic w, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                      input logic [3:0] be, input logic r, input logic [AW-1:0] ra,
                      input logic push, input logic [DW-1:0] exp, input logic exp_perr);
        exp_t e;
        bus.we         = w;
        bus.write_addr = wa;
        bus.data_in    = wd;
        bus.byte_en    = be;
        bus.re         = r;
        bus.read_addr  = ra;
        if (r && push) begin
            e.data = exp;
            e.perr = exp_perr;
            e.cyc  = cycle_cnt + 1 + OUTPUT_REG;
            sb_q.push_back(e);
        end
        @(negedge clk);
        bus.we = 1'b0;
        bus.re = 1'b0;
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] be);
        op(1'b1, a, d, be, 1'b0, '0, 1'b0, '0, 1'b0);
    endtask

    task automatic rd(input logic [AW-1:0] a, input logic [DW-1:0] exp, input logic exp_perr);
        op(1'b0, '0, '0, 4'h0, 1'b1, a, 1'b1, exp, exp_perr);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // Counts busy cycles while hammering a write to addr 2 and a read of
    // addr 2; both must be ignored during the clear.
    task automatic count_busy(output int cnt);
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.busy !== 1'b1) break;
            cnt++;
            op(1'b1, 4'd2, 32'hFFFF_FFFF, 4'hF, 1'b1, 4'd2, 1'b0, '0, 1'b0);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int nb;
        n_cmp = 0;
        n_mis = 0;
        reset          = 1'b1;
        bus.we         = 1'b0;
        bus.re         = 1'b0;
        bus.data_in    = '0;
        bus.byte_en    = '0;
        bus.write_addr = '0;
        bus.read_addr  = '0;
        idle(3);

        // Reset state
        check("reset_data_out", bus.data_out, 32'h0);
        check("reset_data_valid", {31'b0, bus.data_valid}, 32'h0);
        check("reset_busy", {31'b0, bus.busy}, 32'h1);

        // Clear length, then all zero
        reset = 1'b0;
        count_busy(nb);
        check("busy_cycles", nb, 32'd16);
        for (int a = 0; a < 16; a++) rd(a[AW-1:0], 32'h0, 1'b0);

        // Byte-lane writes
        wr(4'd3, 32'hDEAD_BEEF, 4'hF);
        wr(4'd3, 32'h1122_3344, 4'h5);
        rd(4'd3, 32'hDE22_BE44, 1'b0);
        wr(4'd3, 32'h0000_0000, 4'h0);          // no lanes enabled: no-op
        rd(4'd3, 32'hDE22_BE44, 1'b0);

        // Write-first same-address forwarding
        wr(4'd5, 32'hAAAA_AAAA, 4'hF);
        op(1'b1, 4'd5, 32'h5555_5555, 4'h3, 1'b1, 4'd5, 1'b1, 32'hAAAA_5555, 1'b0);
        rd(4'd5, 32'hAAAA_5555, 1'b0);

        // Write on the cycle after the read issue does not affect it
        rd(4'd5, 32'hAAAA_5555, 1'b0);
        wr(4'd5, 32'h0000_0000, 4'hF);
        rd(4'd5, 32'h0000_0000, 1'b0);

        // Fill then stream a read every cycle
        for (int a = 0; a < 16; a++) wr(a[AW-1:0], a, 4'hF);
        for (int a = 0; a < 16; a++) rd(a[AW-1:0], a, 1'b0);
        idle(4);

        // Reset while a read is in flight: its data_valid is cancelled
        bus.re        = 1'b1;
        bus.read_addr = 4'd7;
        @(posedge clk);
        #1;
        reset  = 1'b1;
        bus.re = 1'b0;
        #1;
        check("midread_valid", {31'b0, bus.data_valid}, 32'h0);
        check("midread_data_out", bus.data_out, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        // Reset again when clear_cnt reaches 7: clear restarts from 0
        idle(7);
        reset = 1'b1;
        @(negedge clk);
        check("reclear_busy_in_reset", {31'b0, bus.busy}, 32'h1);
        reset = 1'b0;
        count_busy(nb);
        check("reclear_busy_cycles", nb, 32'd16);
        rd(4'd2, 32'h0, 1'b0);
        rd(4'd7, 32'h0, 1'b0);
        rd(4'd15, 32'h0, 1'b0);

`ifdef DUAL_PORT_RAM_BE_PARITY_EN
        // Corrupt one stored data bit; its stored parity no longer matches
        wr(4'd1, 32'h0000_00FF, 4'hF);
        idle(1);
        dut.mem_array[1][0] = 1'b0;
        rd(4'd1, 32'h0000_00FE, 1'b1);
        rd(4'd0, 32'h0000_0000, 1'b0);
`endif

        idle(5);
        check("scoreboard_drained", sb_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    // Bound on the whole run
    initial begin
        #200000;
        n_cmp++;
        n_mis++;
        $display("FAIL watchdog: run did not end, got time %0t, want under 200000", $time);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule

// File: doc/dual_port_ram_be.md
Name: dual_port_ram_be

Overview:
Single-clock simple dual-port RAM, successor to the team's basic dual-port RAM. Adds:
- per-byte write enables
- a qualified read handshake (re / data_valid)
- selectable 1- or 2-cycle read latency
- write-first same-address forwarding
- a post-reset clear sequencer, so memory contents are defined
Used as frame/line buffer and register-file backing store in the video and CPU blocks.

Parameters:
- DATA_WIDTH, 32, data word width in bits; must be a multiple of 8.
- ADDR_WIDTH, 12, address width; depth = 2^ADDR_WIDTH words.
- OUTPUT_REG, 0, 0 = read latency 1 cycle; 1 = extra output register, latency 2 cycles.
- CLEAR_ON_RESET, 1, 1 = zero every word after reset; 0 = skip the clear; contents undefined.

Ports:
- clock  input  1  sole clock, all logic on posedge.
- reset  input  1  asynchronous, active-high reset.
- data_in  input  DATA_WIDTH  write data.
- byte_en  input  DATA_WIDTH/8  per-lane write enable; bit i covers data_in[8i+7:8i].
- write_addr  input  ADDR_WIDTH  write address.
- we  input  1  write strobe.
- read_addr  input  ADDR_WIDTH  read address.
- re  input  1  read strobe.
- data_out  output  DATA_WIDTH  read data.
- data_valid  output  1  one-cycle qualifier for data_out.
- busy  output  1  high while the clear sequence runs.

Behaviour:
- Reset (async, active-high):
  - data_out = 0, data_valid = 0, in-flight reads discarded.
  - Clear counter = 0.
  - State = CLEAR with busy = 1 if CLEAR_ON_RESET, else READY with busy = 0.
  - Memory array itself has no reset.
- FSM states: CLEAR, READY.
- CLEAR:
  - Each cycle writes all-zero to address clear_cnt, then increments it.
  - After writing address 2^ADDR_WIDTH-1, moves to READY on the next edge. Total duration is exactly 2^ADDR_WIDTH cycles.
  - busy = 1 throughout; it reads 0 on the first READY cycle.
  - we and re are ignored (no write, no data_valid).
- READY:
  - Write: on the edge where we = 1, lanes with byte_en[i] = 1 are updated; other lanes are unchanged. we = 1 with byte_en = 0 is a no-op.
  - Read: on the edge where re = 1, read_addr is sampled. data_out and data_valid = 1 appear 1 cycle later (OUTPUT_REG = 0) or 2 cycles later (OUTPUT_REG = 1). data_valid is high for exactly one cycle per accepted read.
  - A read may be issued every cycle; full throughput, results in issue order.
  - When data_valid = 0, data_out holds its previous value.
- Same cycle, same address (we & re, write_addr == read_addr): write-first.
  - Returned word = new data on enabled lanes, old stored data on disabled lanes.
  - Merge uses the data/byte_en sampled on that edge.
- A write to the same address on the cycle after a read issue does not affect that read; it returns the data as of the issue edge.
- Addresses are power-of-two sized: no out-of-range case, no wrap logic beyond the counter's natural wrap at the end of the clear.
- Reset mid-CLEAR: the clear restarts from address 0, and busy stays high for a full 2^ADDR_WIDTH cycles after reset release.
- Reset mid-read: the pending data_valid is cancelled.

Optional Feature:
- Macro: DUAL_PORT_RAM_BE_PARITY_EN.
- Defined:
  - Each byte lane stores an extra even-parity bit; array width is DATA_WIDTH + DATA_WIDTH/8.
  - Parity is generated on write; CLEAR writes parity 0.
  - On read, parity is recomputed per lane and an extra output port parity_error (1 bit) asserts, aligned with data_valid, if any lane mismatches.
  - Forwarded bytes use freshly generated parity.
  - parity_error resets to 0 and is 0 whenever data_valid = 0.
- Undefined: no parity storage and no parity_error port.

Test Plan:
1. ADDR_WIDTH = 4, CLEAR_ON_RESET = 1, release reset -> busy = 1 for exactly 16 cycles, then 0; reads of addresses 0..15 all return 0x00000000.
2. Write 0xDEADBEEF to addr 3 with byte_en 1111, then 0x11223344 with byte_en 0101, then re addr 3 -> data_out 0xDE22BE44. data_valid is 1 cycle after re (OUTPUT_REG = 0) and 2 cycles after re (OUTPUT_REG = 1).
3. Addr 5 holds 0xAAAAAAAA; same cycle we = 1, re = 1, addr 5, data 0x55555555, byte_en 0011 -> data_out 0xAAAA5555, and a later read returns 0xAAAA5555.
4. Assert reset when clear_cnt = 7; hold we = 1 to addr 2 during busy -> busy lasts 16 cycles after release, and addr 2 reads 0.
5. Fill addrs 0..15 with value = addr; re every cycle for 0..15 -> data_valid high 16 consecutive cycles, data 0..15 in order.
6. With the parity macro defined, write 0x000000FF to addr 1, then flip one stored data bit via a hierarchical deposit -> read gives parity_error = 1 together with data_valid; reading an untouched address gives parity_error = 0.
